// File: rtl/demux2_pkg.sv
// Shared types and helpers for the two-way stream demultiplexer.
package demux2_pkg;

    // Destination of an incoming beat.
    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    // Index width of a FIFO holding 'depth' entries (depth is a power of 2).
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_1r1w.sv
// Single-read single-write FIFO with registered head and no bypass path.
// Pointers carry one extra MSB so full and empty can be told apart.
module fifo_1r1w
    import demux2_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PtrW = ptr_width(depth_p);
    localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

    logic [width_p-1:0] r_mem [depth_p];
    logic [PtrW:0]      r_wrPtr;
    logic [PtrW:0]      r_rdPtr;
    logic [PtrW:0]      w_count;

    assign empty_o = (r_wrPtr == r_rdPtr);
    assign full_o  = (r_wrPtr[PtrW] != r_rdPtr[PtrW]) &&
                     (r_wrPtr[PtrW-1:0] == r_rdPtr[PtrW-1:0]);
    assign data_o  = r_mem[r_rdPtr[PtrW-1:0]];
    assign w_count = r_wrPtr - r_rdPtr;

    // Storage write; cleared on reset so the head reads zero while flushed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < depth_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push_i) begin
            r_mem[r_wrPtr[PtrW-1:0]] <= data_i;
        end
    end

    // Pointer advance; push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (push_i) begin
                r_wrPtr <= r_wrPtr + PtrOne;
            end
            if (pop_i) begin
                r_rdPtr <= r_rdPtr + PtrOne;
            end
        end
    end

    // Occupancy never exceeds the number of entries.
    assert property (@(posedge clk_i) disable iff (reset_i)
        int'(w_count) <= depth_p);

    // The steering logic must never push into a full FIFO.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && full_o));

    // The steering logic must never pop an empty FIFO.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(pop_i && empty_o));

    // A held head stays put until popped (an intervening flush is allowed).
    assert property (@(posedge clk_i) disable iff (reset_i)
        (!empty_o && !pop_i) |=> (empty_o || data_o == $past(data_o)));

endmodule

// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer: each accepted beat goes to the FIFO picked
// by select_i, so a stalled consumer only blocks beats aimed at its side.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               select_i,
    output logic               valid_a_o,
    input  logic               ready_a_i,
    output logic [width_p-1:0] data_a_o,
    output logic               valid_b_o,
    input  logic               ready_b_i,
    output logic [width_p-1:0] data_b_o
);

    sel_e w_sel;
    logic w_fullA;
    logic w_fullB;
    logic w_emptyA;
    logic w_emptyB;
    logic w_pushA;
    logic w_pushB;
    logic w_popA;
    logic w_popB;

    assign w_sel   = sel_e'(select_i);

    // Full flags are registered, so ready only looks at the targeted side;
    // a pop on a full side does not free a slot in the same cycle.
    assign ready_o = ~reset_i & ((w_sel == SEL_B) ? ~w_fullB : ~w_fullA);

    assign valid_a_o = ~w_emptyA;
    assign valid_b_o = ~w_emptyB;
    assign w_popA    = ready_a_i & ~w_emptyA;
    assign w_popB    = ready_b_i & ~w_emptyB;

    // Steer an accepted beat into exactly one FIFO; the other stays untouched.
    always_comb begin
        w_pushA = 1'b0;
        w_pushB = 1'b0;
        if (valid_i && ready_o) begin
            if (w_sel == SEL_B) begin
                w_pushB = 1'b1;
            end else begin
                w_pushA = 1'b1;
            end
        end
    end

    fifo_1r1w #(
        .width_p (width_p),
        .depth_p (depth_p)
    ) u_fifoA (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_pushA),
        .data_i  (data_i),
        .pop_i   (w_popA),
        .data_o  (data_a_o),
        .full_o  (w_fullA),
        .empty_o (w_emptyA)
    );

    fifo_1r1w #(
        .width_p (width_p),
        .depth_p (depth_p)
    ) u_fifoB (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_pushB),
        .data_i  (data_i),
        .pop_i   (w_popB),
        .data_o  (data_b_o),
        .full_o  (w_fullB),
        .empty_o (w_emptyB)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: routing, backpressure, wrap, reset flush.
module tb_demux2_stream;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       select_i;
    logic       valid_a_o;
    logic       ready_a_i;
    logic [7:0] data_a_o;
    logic       valid_b_o;
    logic       ready_b_i;
    logic [7:0] data_b_o;

    int total = 0;
    int bad   = 0;

    demux2_stream #(
        .width_p (8),
        .depth_p (2)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .select_i  (select_i),
        .valid_a_o (valid_a_o),
        .ready_a_i (ready_a_i),
        .data_a_o  (data_a_o),
        .valid_b_o (valid_b_o),
        .ready_b_i (ready_b_i),
        .data_b_o  (data_b_o)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i   = 1'b1;
        valid_i   = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'hAA;
        ready_a_i = 1'b1;
        ready_b_i = 1'b1;
        repeat (3) step();
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_a: got %b expected 0", valid_a_o); end
        total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_b: got %b expected 0", valid_b_o); end
        total++; if (data_a_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data_a: got %h expected 00", data_a_o); end
        total++; if (data_b_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_data_b: got %h expected 00", data_b_o); end
        valid_i = 1'b0;
        reset_i = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready: got %b expected 1", ready_o); end
        step();
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid_a: got %b expected 0", valid_a_o); end
    endtask

    task automatic test_route();
        ready_a_i = 1'b1;
        ready_b_i = 1'b1;
        valid_i   = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'h11;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL route_ready: got %b expected 1", ready_o); end
        step();
        total++; if (valid_a_o !== 1'b1) begin bad++; $display("[TB] FAIL route_valid_a: got %b expected 1", valid_a_o); end
        total++; if (data_a_o !== 8'h11) begin bad++; $display("[TB] FAIL route_data_a: got %h expected 11", data_a_o); end
        total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL route_b_untouched: got %b expected 0", valid_b_o); end
        select_i = 1'b1;
        data_i   = 8'h22;
        step();
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL route_a_one_cycle: got %b expected 0", valid_a_o); end
        total++; if (valid_b_o !== 1'b1) begin bad++; $display("[TB] FAIL route_valid_b: got %b expected 1", valid_b_o); end
        total++; if (data_b_o !== 8'h22) begin bad++; $display("[TB] FAIL route_data_b: got %h expected 22", data_b_o); end
        valid_i = 1'b0;
        step();
        total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL route_b_one_cycle: got %b expected 0", valid_b_o); end
    endtask

    task automatic test_backpressure();
        ready_a_i = 1'b0;
        ready_b_i = 1'b1;
        valid_i   = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'h01;
        step();
        data_i = 8'h02;
        step();
        data_i = 8'h03;
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready: got %b expected 0", ready_o); end
        total++; if (data_a_o !== 8'h01) begin bad++; $display("[TB] FAIL bp_head_a: got %h expected 01", data_a_o); end
        select_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_other_ready: got %b expected 1", ready_o); end
        step();
        total++; if (valid_b_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid_b: got %b expected 1", valid_b_o); end
        total++; if (data_b_o !== 8'h03) begin bad++; $display("[TB] FAIL bp_data_b: got %h expected 03", data_b_o); end
        total++; if (data_a_o !== 8'h01) begin bad++; $display("[TB] FAIL bp_stall_stable: got %h expected 01", data_a_o); end
        // Full side popping this cycle must still refuse a new beat.
        ready_a_i = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'h04;
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_bypass: got %b expected 0", ready_o); end
        valid_i = 1'b0;
        step();
        total++; if (valid_a_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain_valid: got %b expected 1", valid_a_o); end
        total++; if (data_a_o !== 8'h02) begin bad++; $display("[TB] FAIL bp_drain_order: got %h expected 02", data_a_o); end
        total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_b_drained: got %b expected 0", valid_b_o); end
        step();
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_a_empty: got %b expected 0", valid_a_o); end
    endtask

    task automatic test_stream_wrap();
        logic [7:0] beat;
        ready_a_i = 1'b1;
        ready_b_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            beat     = 8'(i);
            valid_i  = 1'b1;
            select_i = beat[0];
            data_i   = beat;
            #1;
            total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, ready_o); end
            step();
            if (beat[0] == 1'b0) begin
                total++; if (valid_a_o !== 1'b1 || data_a_o !== beat) begin bad++; $display("[TB] FAIL stream_a[%0d]: got v=%b d=%h expected v=1 d=%h", i, valid_a_o, data_a_o, beat); end
                total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL stream_b_idle[%0d]: got %b expected 0", i, valid_b_o); end
            end else begin
                total++; if (valid_b_o !== 1'b1 || data_b_o !== beat) begin bad++; $display("[TB] FAIL stream_b[%0d]: got v=%b d=%h expected v=1 d=%h", i, valid_b_o, data_b_o, beat); end
                total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL stream_a_idle[%0d]: got %b expected 0", i, valid_a_o); end
            end
        end
        valid_i = 1'b0;
        step();
        total++; if (valid_a_o !== 1'b0 || valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL stream_drained: got a=%b b=%b expected 0 0", valid_a_o, valid_b_o); end
    endtask

    task automatic test_simul_push_pop();
        ready_a_i = 1'b0;
        ready_b_i = 1'b1;
        valid_i   = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'h55;
        step();
        total++; if (data_a_o !== 8'h55) begin bad++; $display("[TB] FAIL simul_first: got %h expected 55", data_a_o); end
        ready_a_i = 1'b1;
        data_i    = 8'h66;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL simul_ready: got %b expected 1", ready_o); end
        step();
        total++; if (valid_a_o !== 1'b1) begin bad++; $display("[TB] FAIL simul_valid: got %b expected 1", valid_a_o); end
        total++; if (data_a_o !== 8'h66) begin bad++; $display("[TB] FAIL simul_data: got %h expected 66", data_a_o); end
        valid_i = 1'b0;
        step();
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL simul_count: got %b expected 0", valid_a_o); end
    endtask

    task automatic test_mid_reset();
        ready_a_i = 1'b0;
        ready_b_i = 1'b0;
        valid_i   = 1'b1;
        select_i  = 1'b0;
        data_i    = 8'hA1; step();
        data_i    = 8'hA2; step();
        select_i  = 1'b1;
        data_i    = 8'hB1; step();
        data_i    = 8'hB2; step();
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_full_b: got %b expected 0", ready_o); end
        total++; if (valid_a_o !== 1'b1 || valid_b_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_filled: got a=%b b=%b expected 1 1", valid_a_o, valid_b_o); end
        valid_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        total++; if (valid_a_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_a: got %b expected 0", valid_a_o); end
        total++; if (valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_async_b: got %b expected 0", valid_b_o); end
        #1;
        reset_i   = 1'b0;
        ready_a_i = 1'b1;
        ready_b_i = 1'b1;
        step();
        total++; if (valid_a_o !== 1'b0 || valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_stale: got a=%b b=%b expected 0 0", valid_a_o, valid_b_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready: got %b expected 1", ready_o); end
        step();
        total++; if (valid_a_o !== 1'b0 || valid_b_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_still_empty: got a=%b b=%b expected 0 0", valid_a_o, valid_b_o); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_stream_wrap();
        test_simul_push_pop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- Sequential 1-to-2 stream demultiplexer: the receiving end of a two-input stream mux.
- Accepts one ready/valid input stream and routes each beat to output A or output B according to select_i sampled with the beat.
- Each output has its own small FIFO, so a stalled consumer on one side does not block beats destined for the other side.
- Sits downstream of the mux2-style steering logic in the lab datapath.

Parameters:
- width_p, 8, data width of every beat in bits (>=1).
- depth_p, 2, entries per output FIFO; power of 2, >=2.

Ports:
- clk_i  input  1  rising-edge clock.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input can accept a beat this cycle.
- data_i  input  width_p  input beat data.
- select_i  input  1  destination of the current beat: 0 = A, 1 = B.
- valid_a_o  output  1  output A has a beat.
- ready_a_i  input  1  consumer A accepts.
- data_a_o  output  width_p  output A head data.
- valid_b_o  output  1  output B has a beat.
- ready_b_i  input  1  consumer B accepts.
- data_b_o  output  width_p  output B head data.

Behaviour:
- Reset: one clock, clk_i; reset_i is asynchronous and active-high.
  - While reset_i=1: both FIFOs empty, valid_a_o=0, valid_b_o=0, ready_o=0, data_a_o/data_b_o=0.
  - Reset asserted mid-operation flushes all stored beats immediately; stored data is lost.
- Input handshake:
  - ready_o = ~reset_i & (select_i ? ~full_b : ~full_a). This is combinational from select_i and registered full flags.
  - A beat is accepted on a rising edge when valid_i & ready_o.
  - select_i and data_i are meaningful only while valid_i=1.
  - A beat is pushed only into the FIFO named by select_i; the other FIFO is untouched.
- Output handshake (per side X in {A,B}):
  - valid_x_o = ~empty_x; data_x_o = FIFO head. Both are registered state with no combinational path from data_i.
  - A pop occurs on a rising edge when valid_x_o & ready_x_i.
  - data_x_o holds stable while valid_x_o=1 and ready_x_i=0.
- Latency:
  - Exactly 1 cycle from acceptance to valid_x_o=1 on an empty FIFO; there is no bypass.
  - Throughput is 1 beat/cycle when the consumer is always ready and depth_p>=2.
- Ordering: beats to the same side emerge in acceptance order. There is no ordering relation between A and B.
- Boundary conditions:
  - Full: FIFO X holds depth_p beats, so ready_o=0 while select_i targets X. No push-when-full-with-simultaneous-pop bypass: ready_o stays 0 that cycle even if X pops.
  - Empty: valid_x_o=0. ready_x_i is ignored and pointers do not move.
  - Simultaneous push and pop on the same non-empty, non-full FIFO: both occur and the occupancy count is unchanged.
  - Wrap-around: read/write pointers are log2(depth_p) bits and wrap naturally. Occupancy is tracked with log2(depth_p)+1 bits, or an extra pointer MSB, to distinguish full from empty.
  - select_i changing while valid_i=1 and ready_o=0 is legal. ready_o re-evaluates against the new target.
- Assertions:
  - Occupancy never exceeds depth_p.
  - No push when full.
  - No pop when empty.
  - data_x_o stable under a stall.

Decomposition:
- Package demux2_pkg:
  - typedef enum logic {SEL_A=1'b0, SEL_B=1'b1} sel_e.
  - Shared localparam helper for pointer width, $clog2(depth_p).
- Sub-module fifo_1r1w (width_p, depth_p), instantiated twice.
  - Ports: clk_i, reset_i, push_i, data_i, pop_i, data_o, full_o, empty_o.
  - No bypass; asynchronous active-high reset.
- Top level contains only push/pop steering and the ready_o mux.

Test Plan:
- Reset: assert reset_i for 3 cycles with valid_i=1 -> ready_o=0, valid_a_o=0, valid_b_o=0. After release ready_o=1.
- Route: send 0x11 (sel 0), then 0x22 (sel 1), with both consumers ready -> the cycle after each accept, data_a_o=0x11 with valid_a_o=1, and data_b_o=0x22 with valid_b_o=1. Each valid stays high 1 cycle.
- Backpressure A:
  - ready_a_i=0; send 0x01, 0x02 to A -> third beat to A sees ready_o=0.
  - Same cycle with select_i=1 -> ready_o=1, and 0x03 is delivered on B.
  - Then ready_a_i=1 -> A emits 0x01 then 0x02 in order.
- Stream and wrap: consumers always ready; send 0x00..0x0F alternating sel -> A gets evens and B gets odds in order. No beat is lost after pointers wrap 4+ times; one beat per cycle is sustained.
- Simultaneous push/pop: A holds 1 beat (0x55), ready_a_i=1, push 0x66 to A same cycle -> next cycle data_a_o=0x66 and valid_a_o=1.
- Mid-operation reset: both FIFOs full, pulse reset_i asynchronously for 2ns between edges -> valid_a_o and valid_b_o drop immediately. After release, no stale beat appears on either output.
